spike_dispatcher: RTL

Consumer-side controller for the spike scheduler FIFO. Pops one queued event at a time, decodes its virtual-weight field and source address, and drives the neuron-update port. A real event (virts = 0) is broadcast as one synaptic update per post-synaptic neuron 0..N-1. A virtual event (virts ≠ 0) is a single direct update of the addressed neuron. It sits between the scheduler FIFO output and the neuron/synapse memory update path.

---
 rtl/snn_pkg.sv | 15 +
 rtl/spike_dispatcher.sv | 108 ++++++++++
 2 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike scheduling path.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    ISSUE,
    DONE
  } state_t;

  localparam logic OP_SYN  = 1'b0;
  localparam logic OP_VIRT = 1'b1;

endpackage

// File: rtl/spike_dispatcher.sv
// Pops one scheduler event at a time and drives the neuron-update port:
// a real event sweeps all N post-synaptic neurons, a virtual event is one update.
module spike_dispatcher
  import snn_pkg::*;
#(
  parameter int N         = 256,
  parameter int M         = 8,
  parameter int VIRT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sched_empty,
  input  logic [VIRT_BITS+M-1:0] sched_data_out,
  output logic                   ctrl_sched_pop_n,
  input  logic                   ctrl_halt,
  input  logic                   neur_stall,
  output logic                   ctrl_neur_en,
  output logic                   ctrl_neur_op,
  output logic [M-1:0]           ctrl_neurmem_addr,
  output logic [M-1:0]           ctrl_pre_addr,
  output logic [VIRT_BITS-1:0]   ctrl_virts,
  output logic                   busy,
  output logic                   evt_done
);

  localparam logic [M-1:0] LAST = M'(N - 1);

  state_t               state;
  logic [VIRT_BITS-1:0] ev_virts;
  logic [M-1:0]         cnt;
  logic [VIRT_BITS-1:0] data_virts;
  logic [M-1:0]         data_addr;
  logic                 accept;

  always_comb begin
    data_virts = sched_data_out[VIRT_BITS+M-1 -: VIRT_BITS];
    data_addr  = sched_data_out[M-1:0];
    accept     = ctrl_neur_en && !neur_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ev_virts          <= '0;
      cnt               <= '0;
      ctrl_sched_pop_n  <= 1'b1;
      ctrl_neur_en      <= 1'b0;
      ctrl_neur_op      <= OP_SYN;
      ctrl_neurmem_addr <= '0;
      ctrl_pre_addr     <= '0;
      ctrl_virts        <= '0;
      busy              <= 1'b0;
      evt_done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!sched_empty && !ctrl_halt) begin
            state            <= POP;
            ctrl_sched_pop_n <= 1'b0;
            busy             <= 1'b1;
          end
        end
        POP: begin
          ctrl_sched_pop_n <= 1'b1;
          state            <= CAPT;
        end
        CAPT: begin
          // The event address lives on in the output registers, so only the
          // weight is kept for the type decode during ISSUE.
          ev_virts     <= data_virts;
          cnt          <= '0;
          ctrl_neur_en <= 1'b1;
          if (|data_virts) begin
            ctrl_neur_op      <= OP_VIRT;
            ctrl_neurmem_addr <= data_addr;
            ctrl_pre_addr     <= '0;
            ctrl_virts        <= data_virts;
          end else begin
            ctrl_neur_op      <= OP_SYN;
            ctrl_neurmem_addr <= '0;
            ctrl_pre_addr     <= data_addr;
            ctrl_virts        <= '0;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (accept) begin
            if (|ev_virts || cnt == LAST) begin
              ctrl_neur_en <= 1'b0;
              evt_done     <= 1'b1;
              state        <= DONE;
            end else begin
              cnt               <= cnt + 1'b1;
              ctrl_neurmem_addr <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          evt_done <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
